// File: rtl/button_debouncer.sv
// Push-button conditioner: multi-flop synchroniser feeding a counter-qualified
// debounce FSM with registered level, rise/fall strobes and a press-toggled level.
module button_debouncer #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic toggle_out
);

    localparam int CNT_W = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        PENDING_HIGH,
        STABLE_HIGH,
        PENDING_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    state_t                 w_state_nx;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nx;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_toggle;
    logic                   w_level_nx;
    logic                   w_rise_nx;
    logic                   w_fall_nx;
    logic                   w_toggle_nx;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // btn_in enters the design only through this chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_count_nx  = r_count;
        w_rise_nx   = 1'b0;
        w_fall_nx   = 1'b0;
        w_toggle_nx = r_toggle;
        case (r_state)
            STABLE_LOW: begin
                if (w_sync) begin
                    w_state_nx = PENDING_HIGH;
                    w_count_nx = '0;
                end
            end
            PENDING_HIGH: begin
                if (!w_sync) begin
                    w_state_nx = STABLE_LOW;
                    w_count_nx = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_nx  = STABLE_HIGH;
                    w_count_nx  = '0;
                    w_rise_nx   = 1'b1;
                    w_toggle_nx = ~r_toggle;
                end else begin
                    w_count_nx = r_count + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!w_sync) begin
                    w_state_nx = PENDING_LOW;
                    w_count_nx = '0;
                end
            end
            PENDING_LOW: begin
                if (w_sync) begin
                    w_state_nx = STABLE_HIGH;
                    w_count_nx = '0;
                end else if (r_count == CNT_LAST) begin
                    w_state_nx = STABLE_LOW;
                    w_count_nx = '0;
                    w_fall_nx  = 1'b1;
                end else begin
                    w_count_nx = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = STABLE_LOW;
                w_count_nx = '0;
            end
        endcase
    end

    // The level follows the state being entered, so it stays high while a release is pending.
    assign w_level_nx = (w_state_nx == STABLE_HIGH) || (w_state_nx == PENDING_LOW);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= STABLE_LOW;
            r_count  <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_count  <= w_count_nx;
            r_level  <= w_level_nx;
            r_rise   <= w_rise_nx;
            r_fall   <= w_fall_nx;
            r_toggle <= w_toggle_nx;
        end
    end

    assign btn_level  = r_level;
    assign btn_rise   = r_rise;
    assign btn_fall   = r_fall;
    assign toggle_out = r_toggle;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_COUNT=4, SYNC_STAGES=2:
// acceptance lands on the 7th edge after the first edge sampling a new input.
module tb_button_debouncer;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic toggle_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_rise   = 0;
    int n_fall   = 0;
    int strobe_err = 0;
    logic prev_strobe = 1'b0;

    // Expected output vector order: {btn_level, btn_rise, btn_fall, toggle_out}
    typedef struct {
        logic       rst;
        logic       btn;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vq[$];

    button_debouncer #(
        .SYNC_STAGES (2),
        .STABLE_COUNT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .toggle_out(toggle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (btn_rise) n_rise++;
        if (btn_fall) n_fall++;
        if (btn_rise && btn_fall) strobe_err++;
        if ((btn_rise || btn_fall) && prev_strobe) strobe_err++;
        prev_strobe = btn_rise || btn_fall;
    end

    task automatic step(input logic r, input logic b);
        rst    = r;
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic b, input int n);
        repeat (n) step(1'b0, b);
    endtask

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {btn_level, btn_rise, btn_fall, toggle_out};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got lvl/rise/fall/tog=%b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        int r0, f0;
        logic b;
        logic [3:0] e;

        rst    = 1'b1;
        btn_in = 1'b0;

        // Reset, clean press, clean release.
        vq.push_back('{1'b1, 1'b0, 4'b0000, "reset0"});
        vq.push_back('{1'b1, 1'b0, 4'b0000, "reset1"});
        for (int i = 0; i < 6; i++) vq.push_back('{1'b0, 1'b1, 4'b0000, "press_wait"});
        vq.push_back('{1'b0, 1'b1, 4'b1101, "press_accept"});
        vq.push_back('{1'b0, 1'b1, 4'b1001, "press_after1"});
        vq.push_back('{1'b0, 1'b1, 4'b1001, "press_after2"});
        for (int i = 0; i < 6; i++) vq.push_back('{1'b0, 1'b0, 4'b1001, "release_wait"});
        vq.push_back('{1'b0, 1'b0, 4'b0011, "release_accept"});
        vq.push_back('{1'b0, 1'b0, 4'b0001, "release_after"});

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].btn);
            check(vq[i].name, vq[i].exp);
        end

        // Bounce: high 3, low 2, then high; last 0->1 sample at edge 5, accepted at edge 11.
        r0 = n_rise;
        for (int k = 0; k < 13; k++) begin
            b = (k < 3) ? 1'b1 : ((k < 5) ? 1'b0 : 1'b1);
            step(1'b0, b);
            if (k < 11)       e = 4'b0001;
            else if (k == 11) e = 4'b1100;
            else              e = 4'b1000;
            check($sformatf("bounce_e%0d", k), e);
        end
        check_int("bounce_rise_count", n_rise - r0, 1);
        hold(1'b0, 8);
        check("bounce_release", 4'b0000);

        // Three press/release pairs from a fresh reset.
        step(1'b1, 1'b0);
        check("toggle_reset", 4'b0000);
        r0 = n_rise;
        f0 = n_fall;
        for (int p = 0; p < 3; p++) begin
            hold(1'b1, 8);
            check($sformatf("toggle_press%0d", p), {3'b100, (p % 2 == 0)});
            hold(1'b0, 8);
            check($sformatf("toggle_release%0d", p), {3'b000, (p % 2 == 0)});
        end
        check_int("toggle_rise_count", n_rise - r0, 3);
        check_int("toggle_fall_count", n_fall - f0, 3);

        // Reset while pending high with count = 2, button held high throughout.
        hold(1'b1, 5);
        check("midrst_pending", 4'b0001);
        step(1'b1, 1'b1);
        check("midrst_cleared", 4'b0000);
        r0 = n_rise;
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1);
            check($sformatf("midrst_requal_e%0d", k), (k < 6) ? 4'b0000 : 4'b1101);
        end
        step(1'b0, 1'b1);
        check("midrst_after", 4'b1001);
        check_int("midrst_rise_count", n_rise - r0, 1);

        // Single-cycle glitch from STABLE_LOW.
        hold(1'b0, 8);
        check("glitch_setup", 4'b0001);
        r0 = n_rise;
        f0 = n_fall;
        step(1'b0, 1'b1);
        check("glitch_e0", 4'b0001);
        for (int k = 1; k < 11; k++) begin
            step(1'b0, 1'b0);
            check($sformatf("glitch_e%0d", k), 4'b0001);
        end
        check_int("glitch_strobes", (n_rise - r0) + (n_fall - f0), 0);

        @(negedge clk);
        check_int("strobe_rules", strobe_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
